// File: rtl/cnn1d_frame_ctrl.sv
// Frame sequencer for cnn1d: admits one frame of samples, captures per-lane scores, reports signed argmax.
// Optional WAIT watchdog and ERROR state are compiled in with `define CNN1D_FRAME_CTRL_TIMEOUT_EN.
module cnn1d_frame_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int FRAME_LEN      = 254,
  parameter int NUM_NEURONS    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int CLS_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ctrl_start,
  output logic                                   ctrl_busy,
  output logic                                   ctrl_error,
  output logic                                   ctrl_ready_in,
  input  logic                                   ctrl_valid_in,
  input  logic [DATA_WIDTH-1:0]                  ctrl_data_in,
  input  logic                                   ctrl_ready_out,
  output logic                                   ctrl_valid_out,
  output logic [DATA_WIDTH-1:0]                  ctrl_data_out,
  input  logic [0:NUM_NEURONS-1]                 score_valid,
  input  logic [0:NUM_NEURONS-1][DATA_WIDTH-1:0] score_data,
  output logic                                   score_ready,
  output logic                                   result_valid,
  input  logic                                   result_ready,
  output logic [CLS_W-1:0]                       result_class,
  output logic [DATA_WIDTH-1:0]                  result_score
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

`ifdef CNN1D_FRAME_CTRL_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT, S_ARGMAX, S_REPORT, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT, S_ARGMAX, S_REPORT} state_t;
`endif

  state_t                                 r_state, w_next;
  logic [CNT_W-1:0]                       r_count;
  logic [0:NUM_NEURONS-1]                 r_flag, w_cap;
  logic [0:NUM_NEURONS-1][DATA_WIDTH-1:0] r_score;
  logic [CLS_W-1:0]                       r_idx, r_best_idx, w_best_idx_nx, r_class;
  logic [DATA_WIDTH-1:0]                  r_best, w_best_nx, w_lane0, r_res_score;
  logic                                   w_xfer, w_all, w_gt, w_start, w_last_cmp;

  assign w_xfer     = (r_state == S_STREAM) && ctrl_valid_in && ctrl_ready_out;
  assign w_cap      = (r_state == S_WAIT) ? (score_valid & ~r_flag) : '0;
  assign w_all      = &(r_flag | w_cap);
  // lane 0 may be captured in the very cycle the set completes
  assign w_lane0    = w_cap[0] ? score_data[0] : r_score[0];
  assign w_gt       = $signed(r_score[r_idx]) > $signed(r_best);
  assign w_best_nx     = w_gt ? r_score[r_idx] : r_best;
  assign w_best_idx_nx = w_gt ? r_idx : r_best_idx;
  assign w_last_cmp = (r_idx == CLS_W'(NUM_NEURONS - 1));
  assign result_class = r_class;
  assign result_score = r_res_score;

`ifdef CNN1D_FRAME_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;
  logic            w_expire;
  assign w_expire = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_start  = ctrl_start && ((r_state == S_IDLE) || (r_state == S_ERROR));

  // Watchdog: held clear while streaming, counts every WAIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= '0;
    end else if (r_state == S_STREAM) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_start = ctrl_start && (r_state == S_IDLE);
`endif

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ctrl_start) w_next = S_STREAM;
        else            w_next = S_IDLE;
      end
      S_STREAM: begin
        if (w_xfer && (r_count == CNT_W'(FRAME_LEN - 1))) w_next = S_WAIT;
        else                                             w_next = S_STREAM;
      end
      S_WAIT: begin
        if (w_all) begin
          if (NUM_NEURONS == 1) w_next = S_REPORT;
          else                  w_next = S_ARGMAX;
        end
`ifdef CNN1D_FRAME_CTRL_TIMEOUT_EN
        else if (w_expire) w_next = S_ERROR;
`endif
        else w_next = S_WAIT;
      end
      S_ARGMAX: begin
        if (w_last_cmp) w_next = S_REPORT;
        else            w_next = S_ARGMAX;
      end
      S_REPORT: begin
        if (result_ready) w_next = S_IDLE;
        else              w_next = S_REPORT;
      end
`ifdef CNN1D_FRAME_CTRL_TIMEOUT_EN
      S_ERROR: begin
        if (ctrl_start) w_next = S_STREAM;
        else            w_next = S_ERROR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    ctrl_ready_in  = 1'b0;
    ctrl_valid_out = 1'b0;
    ctrl_data_out  = '0;
    score_ready    = 1'b0;
    result_valid   = 1'b0;
    ctrl_busy      = 1'b1;
    ctrl_error     = 1'b0;
    case (r_state)
      S_IDLE:   ctrl_busy = 1'b0;
      S_STREAM: begin
        ctrl_valid_out = ctrl_valid_in;
        ctrl_ready_in  = ctrl_ready_out;
        ctrl_data_out  = ctrl_data_in;
      end
      S_WAIT:   score_ready  = 1'b1;
      S_ARGMAX: ctrl_busy    = 1'b1;
      S_REPORT: result_valid = 1'b1;
`ifdef CNN1D_FRAME_CTRL_TIMEOUT_EN
      S_ERROR: begin
        ctrl_busy  = 1'b0;
        ctrl_error = 1'b1;
      end
`endif
      default:  ctrl_busy = 1'b0;
    endcase
  end

  // State, sample count, lane capture and sequential argmax
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_flag      <= '0;
      r_score     <= '0;
      r_idx       <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_class     <= '0;
      r_res_score <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_count <= '0;
        r_flag  <= '0;
      end else begin
        if (w_xfer) r_count <= r_count + CNT_W'(1);
        r_flag <= r_flag | w_cap;
      end
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (w_cap[i]) r_score[i] <= score_data[i];
      end
      if ((r_state == S_WAIT) && w_all) begin
        r_best     <= w_lane0;
        r_best_idx <= '0;
        r_idx      <= CLS_W'(1);
        if (NUM_NEURONS == 1) begin
          r_class     <= '0;
          r_res_score <= w_lane0;
        end
      end
      if (r_state == S_ARGMAX) begin
        r_best     <= w_best_nx;
        r_best_idx <= w_best_idx_nx;
        r_idx      <= r_idx + CLS_W'(1);
        if (w_last_cmp) begin
          r_class     <= w_best_idx_nx;
          r_res_score <= w_best_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_cnn1d_frame_ctrl.sv
// Self-checking bench for cnn1d_frame_ctrl: vector table, hand-written corner sequences, random frames vs argmax model.
// Watchdog scenario runs when CNN1D_FRAME_CTRL_TIMEOUT_EN is defined; otherwise WAIT is checked to persist.
module tb_cnn1d_frame_ctrl;
  localparam int DW = 32;
  localparam int FL = 4;
  localparam int NN = 2;
  localparam int TO = 16;

  typedef logic signed [DW-1:0] sc_t;
  typedef struct {
    sc_t s0;
    sc_t s1;
    int  lag;
    int  bp;
    bit  tog;
    int  ecls;
    sc_t escore;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst, ctrl_start, ctrl_busy, ctrl_error, ctrl_ready_in, ctrl_valid_in;
  logic [DW-1:0]          ctrl_data_in, ctrl_data_out;
  logic                   ctrl_ready_out, ctrl_valid_out, score_ready, result_valid, result_ready;
  logic [0:NN-1]          score_valid;
  logic [0:NN-1][DW-1:0]  score_data;
  logic [0:0]             result_class;
  logic [DW-1:0]          result_score;

  int total = 0;
  int bad   = 0;

  cnn1d_frame_ctrl #(
    .DATA_WIDTH(DW), .FRAME_LEN(FL), .NUM_NEURONS(NN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_start(ctrl_start), .ctrl_busy(ctrl_busy), .ctrl_error(ctrl_error),
    .ctrl_ready_in(ctrl_ready_in), .ctrl_valid_in(ctrl_valid_in), .ctrl_data_in(ctrl_data_in),
    .ctrl_ready_out(ctrl_ready_out), .ctrl_valid_out(ctrl_valid_out), .ctrl_data_out(ctrl_data_out),
    .score_valid(score_valid), .score_data(score_data), .score_ready(score_ready),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_score(result_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: index of the largest signed score, lowest index on ties
  function automatic int ref_argmax(input sc_t s[NN]);
    int b = 0;
    for (int i = 1; i < NN; i++) if (s[i] > s[b]) b = i;
    return b;
  endfunction

  task automatic do_start();
    ctrl_start = 1'b1;
    cyc();
    ctrl_start = 1'b0;
    chk("busy_after_start", ctrl_busy, 1);
    chk("error_after_start", ctrl_error, 0);
  endtask

  task automatic stream(input bit tog);
    sc_t samp[FL];
    int  k = 0;
    int  g = 0;
    bit  hs;
    for (int i = 0; i < FL; i++) samp[i] = sc_t'($urandom);
    while (k < FL && g < 64) begin
      ctrl_valid_in  = 1'b1;
      ctrl_data_in   = samp[k];
      ctrl_ready_out = tog ? g[0] : 1'b1;
      #1;
      chk("stream_valid_out", ctrl_valid_out, 1);
      chk("stream_data_order", ctrl_data_out, samp[k]);
      chk("stream_ready_in", ctrl_ready_in, ctrl_ready_out);
      chk("stream_score_ready", score_ready, 0);
      hs = ctrl_ready_in;
      cyc();
      if (hs) k++;
      g++;
    end
    chk("frame_transfers", k, FL);
    ctrl_ready_out = 1'b1;
    ctrl_data_in   = 32'hFFFF_FFFF;
    #1;
    chk("overrun_ready_in", ctrl_ready_in, 0);
    chk("overrun_valid_out", ctrl_valid_out, 0);
    chk("wait_score_ready", score_ready, 1);
    ctrl_valid_in = 1'b0;
  endtask

  task automatic scores(input sc_t s0, input sc_t s1, input int lag, input int bp,
                        input int ecls, input sc_t esc);
    for (int c = 0; c <= lag; c++) begin
      score_valid[1] = 1'b1;
      score_data[1]  = (c == 0) ? s1 : ~s1;
      score_valid[0] = (c == lag);
      score_data[0]  = s0;
      #1;
      chk("no_early_result", result_valid, 0);
      cyc();
    end
    score_valid = '0;
    score_data  = '0;
    chk("argmax_no_valid", result_valid, 0);
    chk("argmax_busy", ctrl_busy, 1);
    cyc();
    chk("result_valid", result_valid, 1);
    chk("result_class", result_class, ecls);
    chk("result_score", result_score, esc);
    for (int c = 0; c < bp; c++) begin
      cyc();
      chk("hold_valid", result_valid, 1);
      chk("hold_class", result_class, ecls);
      chk("hold_score", result_score, esc);
    end
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
    chk("accepted_valid", result_valid, 0);
    chk("accepted_idle", ctrl_busy, 0);
    chk("class_kept", result_class, ecls);
    chk("score_kept", result_score, esc);
  endtask

  task automatic run_frame(input vec_t v);
    do_start();
    stream(v.tog);
    scores(v.s0, v.s1, v.lag, v.bp, v.ecls, v.escore);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[5];
    vec_t rv;
    sc_t  sc[NN];
    vt[0] = '{32'h0100_0000, 32'hFF00_0000, 0, 0, 1'b0, 0, 32'h0100_0000};
    vt[1] = '{32'hFF80_0000, 32'h0200_0000, 3, 5, 1'b0, 1, 32'h0200_0000};
    vt[2] = '{32'h0080_0000, 32'h0080_0000, 1, 1, 1'b0, 0, 32'h0080_0000};
    vt[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 0, 2, 1'b1, 1, 32'h7FFF_FFFF};
    vt[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 0, 1'b1, 1, 32'hFFFF_FFFF};

    rst = 1'b1; ctrl_start = 1'b0; ctrl_valid_in = 1'b1; ctrl_data_in = 32'hA5A5_A5A5;
    ctrl_ready_out = 1'b1; score_valid = '1; score_data = '1; result_ready = 1'b1;
    cyc(); cyc();
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_error", ctrl_error, 0);
    chk("rst_ready_in", ctrl_ready_in, 0);
    chk("rst_valid_out", ctrl_valid_out, 0);
    chk("rst_data_out", ctrl_data_out, 0);
    chk("rst_score_ready", score_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_class", result_class, 0);
    chk("rst_result_score", result_score, 0);
    rst = 1'b0; ctrl_valid_in = 1'b0; score_valid = '0; score_data = '0; result_ready = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vt[i]);

    // start coincident with reset: reset wins
    rst = 1'b1; ctrl_start = 1'b1;
    cyc();
    rst = 1'b0; ctrl_start = 1'b0;
    chk("start_with_rst_busy", ctrl_busy, 0);

    // reset after two samples, then a clean frame
    do_start();
    ctrl_valid_in = 1'b1; ctrl_ready_out = 1'b1; ctrl_data_in = 32'h11;
    cyc();
    ctrl_data_in = 32'h22;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_busy", ctrl_busy, 0);
    chk("midrst_ready_in", ctrl_ready_in, 0);
    chk("midrst_valid_out", ctrl_valid_out, 0);
    chk("midrst_data_out", ctrl_data_out, 0);
    chk("midrst_score_ready", score_ready, 0);
    chk("midrst_class", result_class, 0);
    chk("midrst_score", result_score, 0);
    ctrl_valid_in = 1'b0;
    run_frame(vt[1]);

`ifdef CNN1D_FRAME_CTRL_TIMEOUT_EN
    do_start();
    stream(1'b0);
    for (int c = 1; c < TO; c++) cyc();
    chk("wd_before_expiry_err", ctrl_error, 0);
    chk("wd_before_expiry_wait", score_ready, 1);
    cyc();
    chk("wd_error", ctrl_error, 1);
    chk("wd_error_busy", ctrl_busy, 0);
    chk("wd_error_score_ready", score_ready, 0);
    chk("wd_error_ready_in", ctrl_ready_in, 0);
    cyc();
    chk("wd_error_sticky", ctrl_error, 1);
    ctrl_ready_out = 1'b1;
    do_start();
    chk("wd_restart_ready_in", ctrl_ready_in, 1);
    stream(1'b0);
    scores(32'h0000_0001, 32'h0000_0002, 0, 0, 1, 32'h0000_0002);
    // both lanes arrive on the expiry cycle: completion wins
    do_start();
    stream(1'b0);
    for (int c = 1; c < TO; c++) cyc();
    scores(32'h0300_0000, 32'h0100_0000, 0, 1, 0, 32'h0300_0000);
    chk("wd_tie_no_error", ctrl_error, 0);
`else
    do_start();
    stream(1'b0);
    for (int c = 0; c < 3 * TO; c++) cyc();
    chk("nowd_still_wait", score_ready, 1);
    chk("nowd_no_error", ctrl_error, 0);
    chk("nowd_busy", ctrl_busy, 1);
    scores(32'h0000_0005, 32'hFFFF_FFF0, 1, 0, 0, 32'h0000_0005);
`endif

    for (int r = 0; r < 16; r++) begin
      sc[0] = sc_t'($urandom);
      sc[1] = ($urandom_range(0, 3) == 0) ? sc[0] : sc_t'($urandom);
      rv.s0     = sc[0];
      rv.s1     = sc[1];
      rv.lag    = $urandom_range(0, 3);
      rv.bp     = $urandom_range(0, 2);
      rv.tog    = 1'($urandom_range(0, 1));
      rv.ecls   = ref_argmax(sc);
      rv.escore = sc[rv.ecls];
      run_frame(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
